mock_tss_multi: RTL and testbench

MOCK_TSS_MULTI -- requirements
Module: mock_tss_multi

---
 rtl/llki_pkg.sv | 14 +
 rtl/mock_tss_multi_if.sv | 29 ++
 rtl/mock_tss_key_loader.sv | 87 ++++++++
 rtl/mock_tss_multi.sv | 70 +++++++
 tb/tb_mock_tss_multi.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/llki_pkg.sv
// Shared LLKI types and default mock-key constants for mock_tss_multi.
package llki_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOADED,
        ST_CLEAR
    } key_st_e;

    localparam int DEF_KEY_WORDS = 5;
    localparam logic [64*DEF_KEY_WORDS-1:0] DEF_KEY_CONST = '0;

endpackage

// File: rtl/mock_tss_multi_if.sv
// LLKI key-load and clear handshake between key controller and TSS.
interface mock_tss_multi_if;

    logic [63:0] llkid_key_data;
    logic        llkid_key_valid;
    logic        llkid_key_ready;
    logic        llkid_key_complete;
    logic        llkid_clear_key;
    logic        llkid_clear_key_ack;

    modport master (
        output llkid_key_data,
        output llkid_key_valid,
        output llkid_clear_key,
        input  llkid_key_ready,
        input  llkid_key_complete,
        input  llkid_clear_key_ack
    );

    modport slave (
        input  llkid_key_data,
        input  llkid_key_valid,
        input  llkid_clear_key,
        output llkid_key_ready,
        output llkid_key_complete,
        output llkid_clear_key_ack
    );

endinterface

// File: rtl/mock_tss_key_loader.sv
// Key-load FSM and key register; fills key words in order, clear wipes all.
module mock_tss_key_loader
    import llki_pkg::*;
#(
    parameter int KEY_WORDS = DEF_KEY_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    mock_tss_multi_if.slave         llki,
    output logic [64*KEY_WORDS-1:0] key_reg,
    output logic                    key_loaded
);

    localparam int IW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(KEY_WORDS - 1);

    key_st_e                  state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [64*KEY_WORDS-1:0]  key_q, key_d;
    logic                     loaded_q, loaded_d;
    logic                     cmpl_q, cmpl_d;
    logic                     ack_q, ack_d;
    logic                     accept;

    assign llki.llkid_key_ready     = (state_q == ST_IDLE) ||
                                      (state_q == ST_LOAD);
    assign llki.llkid_key_complete  = cmpl_q;
    assign llki.llkid_clear_key_ack = ack_q;
    assign accept  = llki.llkid_key_valid && llki.llkid_key_ready;
    assign key_reg    = key_q;
    assign key_loaded = loaded_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = key_q;
        loaded_d = loaded_q;
        cmpl_d   = 1'b0;
        ack_d    = 1'b0;
        // Clear outranks any word offered in the same cycle.
        if (llki.llkid_clear_key) begin
            state_d  = ST_CLEAR;
            idx_d    = '0;
            key_d    = '0;
            loaded_d = 1'b0;
            ack_d    = (state_q != ST_CLEAR);
        end else begin
            unique case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        key_d[64*idx_q +: 64] = llki.llkid_key_data;
                        if (idx_q == LAST) begin
                            state_d  = ST_LOADED;
                            loaded_d = 1'b1;
                            cmpl_d   = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOADED: state_d = ST_LOADED;
                ST_CLEAR:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            key_q    <= '0;
            loaded_q <= 1'b0;
            cmpl_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            key_q    <= key_d;
            loaded_q <= loaded_d;
            cmpl_q   <= cmpl_d;
            ack_q    <= ack_d;
        end
    end

endmodule

// File: rtl/mock_tss_multi.sv
// Multi-channel mock TSS: per-channel XOR with loaded key and KEY_CONST.
// Define MOCK_TSS_OUTPUT_GATE_EN to force outputs to zero until a key is held.
module mock_tss_multi
    import llki_pkg::*;
#(
    parameter int KEY_WORDS = DEF_KEY_WORDS,
    parameter int CHANNELS  = 4,
    parameter int CH_WIDTH  = 64,
    parameter logic [64*KEY_WORDS-1:0] KEY_CONST = DEF_KEY_CONST
) (
    input  logic                         clk,
    input  logic                         rst,
    mock_tss_multi_if.slave              llki,
    input  logic [CHANNELS*CH_WIDTH-1:0] core_in,
    input  logic [CHANNELS-1:0]          core_in_valid,
    output logic [CHANNELS*CH_WIDTH-1:0] core_out,
    output logic [CHANNELS-1:0]          core_out_valid,
    output logic                         key_loaded
);

    localparam int DW = CHANNELS * CH_WIDTH;

    if (DW > 64 * KEY_WORDS) begin : g_bad_cfg
        $error("CHANNELS*CH_WIDTH exceeds 64*KEY_WORDS");
    end

    logic [64*KEY_WORDS-1:0] key_reg;
    logic [DW-1:0]           out_d, out_q;
    logic [CHANNELS-1:0]     vld_q;
    logic                    unused_key_bits;

    mock_tss_key_loader #(
        .KEY_WORDS (KEY_WORDS)
    ) u_key_loader (
        .clk        (clk),
        .rst        (rst),
        .llki       (llki),
        .key_reg    (key_reg),
        .key_loaded (key_loaded)
    );

    // Key words beyond the channel span are held but never mixed in.
    assign unused_key_bits = ^key_reg;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign out_d[c*CH_WIDTH +: CH_WIDTH] =
            core_in[c*CH_WIDTH +: CH_WIDTH] ^
            key_reg[c*CH_WIDTH +: CH_WIDTH] ^
            KEY_CONST[c*CH_WIDTH +: CH_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            vld_q <= '0;
        end else begin
            out_q <= out_d;
            vld_q <= core_in_valid;
        end
    end

`ifdef MOCK_TSS_OUTPUT_GATE_EN
    assign core_out       = key_loaded ? out_q : '0;
    assign core_out_valid = key_loaded ? vld_q : '0;
`else
    assign core_out       = out_q;
    assign core_out_valid = vld_q;
`endif

endmodule

// File: tb/tb_mock_tss_multi.sv
// Bench for mock_tss_multi: directed table, reset sequence, random vs model.
module tb_mock_tss_multi;

    localparam logic [319:0] KC = {
        64'h0F1E_2D3C_4B5A_6978, 64'hDEAD_BEEF_0BAD_F00D,
        64'h1357_9BDF_2468_ACE0, 64'hA5A5_5A5A_C3C3_3C3C,
        64'h0123_4567_89AB_CDEF};

    logic         clk;
    logic         rst;
    logic [255:0] core_in;
    logic [3:0]   core_in_valid;
    logic [255:0] out0, outk;
    logic [3:0]   ov0, ovk;
    logic         ld0, ldk;

    mock_tss_multi_if if0();
    mock_tss_multi_if ifk();

    assign ifk.llkid_key_data  = if0.llkid_key_data;
    assign ifk.llkid_key_valid = if0.llkid_key_valid;
    assign ifk.llkid_clear_key = if0.llkid_clear_key;

    mock_tss_multi dut (
        .clk            (clk),
        .rst            (rst),
        .llki           (if0),
        .core_in        (core_in),
        .core_in_valid  (core_in_valid),
        .core_out       (out0),
        .core_out_valid (ov0),
        .key_loaded     (ld0)
    );

    mock_tss_multi #(.KEY_CONST(KC)) dut_k (
        .clk            (clk),
        .rst            (rst),
        .llki           (ifk),
        .core_in        (core_in),
        .core_in_valid  (core_in_valid),
        .core_out       (outk),
        .core_out_valid (ovk),
        .key_loaded     (ldk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0]  mkey [5];
    int           mn;
    bit           m_ld, m_clr, m_cmp, m_ack;
    logic [255:0] m_out0, m_outk;
    logic [3:0]   m_ov;
    logic [319:0] kc_v;

    typedef struct {
        bit           clr;
        bit           vld;
        logic [63:0]  d;
        logic [255:0] cin;
        logic [3:0]   cv;
        bit           rdy;
        bit           cmp;
        bit           ack;
        bit           ld;
        logic [255:0] out;
        logic [3:0]   ov;
    } vec_t;

    vec_t tv [15];

    function automatic logic [255:0] p4(logic [63:0] a, logic [63:0] b,
                                        logic [63:0] c, logic [63:0] d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(bit clr, bit vld, logic [63:0] d,
                                logic [255:0] cin, logic [3:0] cv,
                                bit rdy, bit cmp, bit ack, bit ld,
                                logic [255:0] out, logic [3:0] ov);
        vec_t v;
        v.clr = clr; v.vld = vld; v.d = d; v.cin = cin; v.cv = cv;
        v.rdy = rdy; v.cmp = cmp; v.ack = ack; v.ld = ld;
        v.out = out; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] a,
                       input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic drive(input bit r, input bit clr, input bit vld,
                         input logic [63:0] d, input logic [255:0] cin,
                         input logic [3:0] cv);
        rst                 = r;
        if0.llkid_clear_key = clr;
        if0.llkid_key_valid = vld;
        if0.llkid_key_data  = d;
        core_in             = cin;
        core_in_valid       = cv;
    endtask

    // Reference: key words fill in order; output sees the key held before the edge.
    task automatic mstep();
        m_cmp = 0;
        m_ack = 0;
        if (rst) begin
            foreach (mkey[i]) mkey[i] = '0;
            mn = 0; m_ld = 0; m_clr = 0;
            m_out0 = '0; m_outk = '0; m_ov = '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_out0[c*64 +: 64] = core_in[c*64 +: 64] ^ mkey[c];
                m_outk[c*64 +: 64] = core_in[c*64 +: 64] ^ mkey[c] ^
                                     kc_v[c*64 +: 64];
            end
            m_ov = core_in_valid;
            if (if0.llkid_clear_key) begin
                m_ack = !m_clr;
                m_clr = 1;
                foreach (mkey[i]) mkey[i] = '0;
                mn = 0; m_ld = 0;
            end else if (m_clr) begin
                m_clr = 0;
            end else if (if0.llkid_key_valid && !m_ld) begin
                mkey[mn] = if0.llkid_key_data;
                mn++;
                if (mn == 5) begin
                    m_ld = 1;
                    m_cmp = 1;
                end
            end
        end
    endtask

    function automatic logic [255:0] gate_o(bit ld, logic [255:0] v);
`ifdef MOCK_TSS_OUTPUT_GATE_EN
        return ld ? v : '0;
`else
        return v;
`endif
    endfunction

    function automatic logic [3:0] gate_v(bit ld, logic [3:0] v);
`ifdef MOCK_TSS_OUTPUT_GATE_EN
        return ld ? v : '0;
`else
        return v;
`endif
    endfunction

    task automatic mcheck();
        chk("m_ready0", 256'(if0.llkid_key_ready), 256'(!m_ld && !m_clr));
        chk("m_ready_k", 256'(ifk.llkid_key_ready), 256'(!m_ld && !m_clr));
        chk("m_cmpl", 256'({if0.llkid_key_complete, ifk.llkid_key_complete}),
            256'({m_cmp, m_cmp}));
        chk("m_ack", 256'({if0.llkid_clear_key_ack, ifk.llkid_clear_key_ack}),
            256'({m_ack, m_ack}));
        chk("m_loaded", 256'({ld0, ldk}), 256'({m_ld, m_ld}));
        chk("m_out0", out0, gate_o(m_ld, m_out0));
        chk("m_out_k", outk, gate_o(m_ld, m_outk));
        chk("m_ov", 256'({ov0, ovk}),
            256'({gate_v(m_ld, m_ov), gate_v(m_ld, m_ov)}));
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep();
        #1;
        mcheck();
    endtask

    logic [63:0]  w [5];
    logic [255:0] rcin;

    initial begin
        kc_v = KC;
        drive(1, 0, 0, '0, '0, '0);
        cyc();
        cyc();
        chk("rst_ready", 256'(if0.llkid_key_ready), 256'(1));
        chk("rst_outs", 256'({ld0, if0.llkid_key_complete,
                              if0.llkid_clear_key_ack, ov0}), 256'(0));
        chk("rst_out", out0, '0);

        tv[0]  = mk(0, 1, 64'h1, '0, 4'hF, 1, 0, 0, 0, '0, 4'hF);
        tv[1]  = mk(0, 1, 64'h2, '0, 4'hF, 1, 0, 0, 0, p4(1, 0, 0, 0), 4'hF);
        tv[2]  = mk(0, 1, 64'h3, '0, 4'hF, 1, 0, 0, 0, p4(1, 2, 0, 0), 4'hF);
        tv[3]  = mk(0, 1, 64'h4, '0, 4'hF, 1, 0, 0, 0, p4(1, 2, 3, 0), 4'hF);
        tv[4]  = mk(0, 1, 64'h5, '0, 4'hF, 0, 1, 0, 1, p4(1, 2, 3, 4), 4'hF);
        tv[5]  = mk(0, 0, 64'h0, p4(1, 3, 0, 0), 4'h3, 0, 0, 0, 1,
                    p4(0, 1, 3, 4), 4'h3);
        tv[6]  = mk(0, 1, 64'hDEAD, '0, 4'hF, 0, 0, 0, 1, p4(1, 2, 3, 4), 4'hF);
        tv[7]  = mk(0, 0, 64'h0, '0, 4'hF, 0, 0, 0, 1, p4(1, 2, 3, 4), 4'hF);
        tv[8]  = mk(1, 0, 64'h0, '0, 4'hF, 0, 0, 1, 0, p4(1, 2, 3, 4), 4'hF);
        tv[9]  = mk(0, 0, 64'h0, '0, 4'hF, 1, 0, 0, 0, '0, 4'hF);
        tv[10] = mk(0, 1, 64'h7, '0, 4'hF, 1, 0, 0, 0, '0, 4'hF);
        tv[11] = mk(0, 1, 64'h8, '0, 4'hF, 1, 0, 0, 0, p4(7, 0, 0, 0), 4'hF);
        tv[12] = mk(1, 1, 64'h9, '0, 4'hF, 0, 0, 1, 0, p4(7, 8, 0, 0), 4'hF);
        tv[13] = mk(0, 0, 64'h0, '0, 4'hF, 1, 0, 0, 0, '0, 4'hF);
        tv[14] = mk(0, 1, 64'hA, '0, 4'h5, 1, 0, 0, 0, '0, 4'h5);

        for (int i = 0; i < 15; i++) begin
            drive(0, tv[i].clr, tv[i].vld, tv[i].d, tv[i].cin, tv[i].cv);
            cyc();
            chk($sformatf("tv%0d_ready", i), 256'(if0.llkid_key_ready),
                256'(tv[i].rdy));
            chk($sformatf("tv%0d_cmpl", i), 256'(if0.llkid_key_complete),
                256'(tv[i].cmp));
            chk($sformatf("tv%0d_ack", i), 256'(if0.llkid_clear_key_ack),
                256'(tv[i].ack));
            chk($sformatf("tv%0d_loaded", i), 256'(ld0), 256'(tv[i].ld));
            chk($sformatf("tv%0d_out", i), out0, gate_o(tv[i].ld, tv[i].out));
            chk($sformatf("tv%0d_ov", i), 256'(ov0),
                256'(gate_v(tv[i].ld, tv[i].ov)));
        end

        drive(0, 0, 1, 64'hB, '0, 4'h0);
        cyc();
        drive(1, 0, 1, 64'hC, '0, 4'hF);
        cyc();
        chk("midrst_ready", 256'(if0.llkid_key_ready), 256'(1));
        chk("midrst_outs", 256'({ld0, ov0, out0}), 256'(0));
        drive(0, 0, 0, '0, '0, 4'hF);
        cyc();
        chk("midrst_key", out0, '0);
        foreach (w[i]) w[i] = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, w[i], '0, 4'h0);
            cyc();
            chk("reload_ready", 256'(if0.llkid_key_ready), 256'(i < 4));
        end
        chk("reload_cmpl", 256'(if0.llkid_key_complete), 256'(1));
        chk("reload_loaded", 256'(ld0), 256'(1));
        drive(0, 0, 0, '0, '0, 4'hA);
        cyc();
        chk("reload_key", out0, p4(w[0], w[1], w[2], w[3]));
        chk("reload_cmpl_drop", 256'(if0.llkid_key_complete), 256'(0));

        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 8; c++) rcin[c*32 +: 32] = $urandom;
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 1) == 1),
                  {$urandom, $urandom}, rcin, 4'($urandom));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
